single_port_ram: RTL and testbench

Single-port synchronous RAM: 64 words × 8 bits, one shared address bus, one enable that selects write or read each clock. Used as a small local storage buffer inside larger datapaths. Writes and reads both occur on the rising clock edge. The read data output is registered.

---
 rtl/single_port_ram_if.sv | 32 +++
 rtl/single_port_ram.sv | 48 ++++
 tb/tb_single_port_ram.sv | 138 +++++++++++++
 3 files changed

// File: rtl/single_port_ram_if.sv
//------------------------------------------------------------------------------
// Module      : single_port_ram_if
// Description : Shared address/data/enable bus of the single-port RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface single_port_ram_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  en;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data,
    output addr,
    output en,
    input  q
  );

  modport slave (
    input  data,
    input  addr,
    input  en,
    output q
  );
endinterface

`default_nettype wire

// File: rtl/single_port_ram.sv
//------------------------------------------------------------------------------
// Module      : single_port_ram
// Description : Single-port synchronous RAM, write or registered read per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module single_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic               clk,
  input  logic               rst,
  single_port_ram_if.slave   bus
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;

  // The array carries no reset so that it maps onto a RAM primitive.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      mem_q[bus.addr] <= bus.data;
    end
  end

  always_comb begin
    q_d = q_q;
    if (!bus.en) begin
      q_d = mem_q[bus.addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_single_port_ram.sv
//------------------------------------------------------------------------------
// Module      : tb_single_port_ram
// Description : Directed and randomized checks of single_port_ram against a model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_single_port_ram;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [7:0] model_mem [0:63];
  logic [7:0] model_q;

  single_port_ram_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus_if ();

  single_port_ram #(
    .ADDR_WIDTH (6),
    .DATA_WIDTH (8),
    .DEPTH      (64)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic op(input logic e, input logic [5:0] a, input logic [7:0] d);
    bus_if.en   = e;
    bus_if.addr = a;
    bus_if.data = d;
    @(posedge clk);
    if (e) model_mem[a] = d;
    else if (!rst) model_q = model_mem[a];
    if (rst) model_q = 8'h00;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_q = 8'h00;
    rst     = 1'b1;
    bus_if.en   = 1'b1;
    bus_if.addr = 6'd0;
    bus_if.data = 8'h00;
    op(1'b1, 6'd0, 8'h00);
    op(1'b1, 6'd0, 8'h00);
    check("reset_q", bus_if.q, 8'h00);
    rst = 1'b0;

    // Basic write/read
    op(1'b1, 6'd0, 8'h01);
    op(1'b1, 6'd1, 8'h02);
    op(1'b1, 6'd2, 8'h03);
    check("write_no_q", bus_if.q, 8'h00);
    op(1'b0, 6'd0, 8'h00); check("rd0", bus_if.q, 8'h01);
    op(1'b0, 6'd1, 8'h00); check("rd1", bus_if.q, 8'h02);
    op(1'b0, 6'd2, 8'h00); check("rd2", bus_if.q, 8'h03);

    // q holds during write
    op(1'b1, 6'd5, 8'hAA); check("hold_on_wr", bus_if.q, 8'h03);
    op(1'b0, 6'd5, 8'h00); check("rd5", bus_if.q, 8'hAA);

    // Overwrite / read-after-write
    op(1'b1, 6'd7, 8'h55);
    op(1'b1, 6'd7, 8'hC3);
    op(1'b0, 6'd7, 8'h00); check("overwrite7", bus_if.q, 8'hC3);

    // Boundary addresses and their neighbours
    op(1'b1, 6'd1,  8'h11);
    op(1'b1, 6'd62, 8'h22);
    op(1'b1, 6'd0,  8'h3C);
    op(1'b1, 6'd63, 8'hE7);
    op(1'b0, 6'd0,  8'h00); check("rd_addr0",  bus_if.q, 8'h3C);
    op(1'b0, 6'd63, 8'h00); check("rd_addr63", bus_if.q, 8'hE7);
    op(1'b0, 6'd1,  8'h00); check("rd_addr1",  bus_if.q, 8'h11);
    op(1'b0, 6'd62, 8'h00); check("rd_addr62", bus_if.q, 8'h22);

    // Asynchronous reset from q=FF, then write-only cycles keep q at 0
    op(1'b1, 6'd20, 8'hFF);
    op(1'b0, 6'd20, 8'h00); check("rd20_ff", bus_if.q, 8'hFF);
    #1 rst = 1'b1;
    model_q = 8'h00;
    #1 check("async_clear", bus_if.q, 8'h00);
    #2 rst = 1'b0;
    op(1'b1, 6'd10, 8'h5A);
    op(1'b1, 6'd11, 8'h6B);
    check("post_rst_wr", bus_if.q, 8'h00);

    // Memory survives a half-cycle reset pulse
    #1 rst = 1'b1;
    #4 rst = 1'b0;
    op(1'b0, 6'd10, 8'h00); check("mem_kept", bus_if.q, 8'h5A);

    // Read edge while rst is held leaves q at 0
    rst = 1'b1;
    op(1'b0, 6'd11, 8'h00); check("rd_in_rst", bus_if.q, 8'h00);
    rst = 1'b0;
    op(1'b0, 6'd11, 8'h00); check("rd_after_rst", bus_if.q, 8'h6B);

    // Fill everything so any random read has a known expected value
    for (int i = 0; i < 64; i++) begin
      op(1'b1, 6'(i), 8'($urandom));
    end
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic       r;
      e = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 15) == 0);
      rst = r;
      if (r) model_q = 8'h00;
      op(e, 6'($urandom), 8'($urandom));
      check("random", bus_if.q, model_q);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
